mem_bridge: RTL

Memory-side slave for the core's picorv32-style native memory interface. Accepts one instruction-fetch, load or store request at a time, applies a programmable wait-state latency, and routes it to an on-chip word-addressed SRAM, a memory-mapped 8N1 UART transmitter, or a fault responder. Sits directly downstream of the core, on its `mem_*` bus, and is the only slave on that bus.

---
 rtl/mem_bridge.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: native-bus slave with wait states,
// word SRAM, 8N1 UART transmitter and fault flag.
//
// Ports:
//   clk, reset      : clock, async active-high reset
//   mem_valid       : request pending (held to ready)
//   mem_instr       : fetch marker, no effect
//   mem_addr/wdata  : byte address / store data
//   mem_wstrb       : byte enables, 0 means read
//   mem_ready       : one-cycle response pulse
//   mem_rdata       : read data, held between responses
//   uart_tx         : serial line, idles high
//   uart_busy       : frame in progress
//   fault           : sticky unmapped-access flag
module mem_bridge #(
  parameter int          MEM_WORDS    = 1024,
  parameter int          WAIT_STATES  = 1,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] UART_BASE    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        uart_busy,
  output logic        fault
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0] MEM_BYTES =
    32'(MEM_WORDS * 4);
  localparam logic [29:0] TX_W =
    UART_BASE[31:2];
  localparam logic [29:0] ST_W =
    UART_BASE[31:2] + 30'd1;
  localparam logic [CW-1:0] CLK_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] WS_LOAD =
    4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic          r_tx;
  logic          r_busy;
  logic [8:0]    r_shift;
  logic [CW-1:0] r_clk;
  logic [3:0]    r_bit;

  logic          r_mem [MEM_WORDS];
  logic [31:0]   r_sram [MEM_WORDS];

  logic          w_accept;
  logic          w_fire;
  logic          w_stall;
  logic          w_is_sram;
  logic          w_is_tx;
  logic          w_is_stat;
  logic          w_unmap;
  logic          w_tx_start;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_unused = mem_instr;

  // Decode works on the latched address so the
  // core may change mem_addr after acceptance.
  assign w_is_sram = r_addr < MEM_BYTES;
  assign w_is_tx   = r_addr[31:2] == TX_W;
  assign w_is_stat = r_addr[31:2] == ST_W;
  assign w_unmap   = !(w_is_sram || w_is_tx ||
                       w_is_stat);
  assign w_idx     = r_addr[AW+1:2];

  // A frame-starting TXDATA write must wait for
  // the transmitter to go idle.
  assign w_stall    = w_is_tx && r_wstrb[0] &&
                      r_busy;
  assign w_tx_start = w_fire && w_is_tx &&
                      r_wstrb[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0 && !w_stall) begin
          w_fire = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
      r_cnt   <= WS_LOAD;
    end else if (r_state == S_WAIT &&
                 r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      r_ready <= w_fire;
      if (w_fire) begin
        if (w_is_sram) begin
          r_rdata <= r_sram[w_idx];
        end else if (w_is_stat) begin
          r_rdata <= {31'b0, r_busy};
        end else begin
          r_rdata <= '0;
        end
        if (w_unmap) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  // SRAM has no reset; a reset during WAIT
  // kills w_fire so no partial write lands.
  always_ff @(posedge clk) begin
    if (w_fire && w_is_sram) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          r_sram[w_idx][8*b +: 8] <=
            r_wdata[8*b +: 8];
        end
      end
    end
  end

  // r_shift holds data bits then stop bit; the
  // start bit is driven directly on frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_shift <= '1;
      r_clk   <= '0;
      r_bit   <= '0;
    end else if (w_tx_start) begin
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
      r_shift <= {1'b1, r_wdata[7:0]};
      r_clk   <= '0;
      r_bit   <= '0;
    end else if (r_busy) begin
      if (r_clk == CLK_LAST) begin
        r_clk <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_clk <= r_clk + 1'b1;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign uart_tx   = r_tx;
  assign uart_busy = r_busy;
  assign fault     = r_fault;

endmodule
